// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DIV_STOP  = 0;

  typedef logic [DEF_CNT_W-1:0] div_t;

  typedef enum logic {
    SEL_IDLE    = 1'b0,
    SEL_PENDING = 1'b1
  } sel_state_e;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/active ratio pair, dclk and wrap outputs.
// Define CLKDIV_DUTY50_EN for a near-50% dclk instead of a one-cycle pulse.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic             dclk_o,
  output logic             wrap_o,
  output logic             wrap_now_o,
  output logic             stopped_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic             dclk_q, dclk_d;
  logic             wrap_q, wrap_d;
  logic             stopped;
  logic             at_end;

  // The incoming write is visible to a same-cycle wrap reload.
  assign shd_d   = we_i ? wdata_i : shd_q;
  assign stopped = (act_q == CNT_W'(DIV_STOP));
  assign at_end  = !stopped && (cnt_q == act_q - CNT_W'(1));

`ifdef CLKDIV_DUTY50_EN
  logic [CNT_W:0] half_hi;
  assign half_hi = ({1'b0, act_d} + (CNT_W+1)'(1)) >> 1;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    dclk_d = dclk_q;
    wrap_d = wrap_q;
    if (en_i) begin
      if (stopped) begin
        cnt_d  = '0;
        act_d  = shd_d;
        dclk_d = 1'b0;
        wrap_d = 1'b0;
      end else begin
        cnt_d  = at_end ? '0 : cnt_q + CNT_W'(1);
        wrap_d = at_end;
        if (at_end) begin
          act_d = shd_d;
        end
`ifdef CLKDIV_DUTY50_EN
        dclk_d = ({1'b0, cnt_d} < half_hi);
`else
        dclk_d = at_end;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      act_q  <= CNT_W'(DEFAULT_DIV);
      shd_q  <= CNT_W'(DEFAULT_DIV);
      dclk_q <= 1'b1;
      wrap_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      dclk_q <= dclk_d;
      wrap_q <= wrap_d;
    end
  end

  assign dclk_o     = dclk_q;
  assign wrap_o     = wrap_q;
  assign wrap_now_o = en_i && at_end;
  assign stopped_o  = stopped;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with glitch-safe output select.
// CLKDIV_DUTY50_EN (in clkdiv_channel) switches dclk to near-50% duty.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = DEF_CNT_W,
  parameter int  DEFAULT_DIV = 2,
  localparam int SEL_W       = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_wsel,
  input  logic [CNT_W-1:0]  div_wdata,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] dclk_vec,
  output logic [NUM_CH-1:0] wrap_vec,
  output logic              dclk,
  output logic              sel_busy,
  output sel_state_e        sel_state
);

  logic [NUM_CH-1:0] ch_we;
  logic [NUM_CH-1:0] ch_wrap_now;
  logic [NUM_CH-1:0] ch_stopped;
  logic [SEL_W-1:0]  active_sel_q, active_sel_d;
  logic              sel_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_we[g] = div_we && (div_wsel == SEL_W'(g));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .we_i       (ch_we[g]),
      .wdata_i    (div_wdata),
      .dclk_o     (dclk_vec[g]),
      .wrap_o     (wrap_vec[g]),
      .wrap_now_o (ch_wrap_now[g]),
      .stopped_o  (ch_stopped[g])
    );
  end

  assign sel_ok = ({{(32-SEL_W){1'b0}}, sel} < 32'(NUM_CH));

  // Switch only on the active channel's period boundary so dclk never glitches.
  always_comb begin
    sel_state    = (sel != active_sel_q) ? SEL_PENDING : SEL_IDLE;
    active_sel_d = active_sel_q;
    if ((sel_state == SEL_PENDING) && sel_ok && en &&
        (ch_wrap_now[active_sel_q] || ch_stopped[active_sel_q])) begin
      active_sel_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_sel_q <= '0;
    end else begin
      active_sel_q <= active_sel_d;
    end
  end

  assign dclk     = dclk_vec[active_sel_q];
  assign sel_busy = (sel != active_sel_q);

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Multi-channel programmable clock divider; successor to the fixed /2, /3, /4, /8 divider.
- NUM_CH independent counters, each with a runtime-writable divide ratio, shadowed and applied at period boundaries.
- A glitch-safe output select switches only at the active channel's period boundary.
- Feeds enable/strobe and slow-clock consumers (LED scan, debouncers, seven-segment refresh) in the lab designs.

Parameters:
- NUM_CH, 4, number of divider channels (2..16).
- CNT_W, 8, width of divide ratio and counters.
- DEFAULT_DIV, 2, reset divide ratio for every channel (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes all counters and outputs.
- div_we  in  1  write strobe for a channel's divide ratio.
- div_wsel  in  SEL_W=$clog2(NUM_CH)  channel index for the write.
- div_wdata  in  CNT_W  new divide ratio N; 0 means stop the channel.
- sel  in  SEL_W  requested output channel.
- dclk_vec  out  NUM_CH  registered per-channel divided outputs.
- wrap_vec  out  NUM_CH  registered one-cycle pulse at each channel's period boundary.
- dclk  out  1  dclk_vec[active_sel], combinational mux of registered bits.
- sel_busy  out  1  high while sel != active_sel (switch pending).

Behaviour:
- Reset (async, rst=0): cnt[i]=0, div_act[i]=div_shd[i]=DEFAULT_DIV, dclk_vec=all 1, wrap_vec=all 1, active_sel=0, sel_busy follows sel.
- Per channel, with en=1 and N=div_act[i]>=1: cnt counts 0..N-1 and wraps to 0.
  - dclk_vec[i] <= (cnt==N-1) and wrap_vec[i] <= (cnt==N-1).
  - Result: output high 1 cycle, low N-1 cycles, period N.
  - N=1: output constantly 1.
  - Example N=3, DEFAULT after reset: 1,0,0,1,0,0…
- Ratio write (div_we=1): div_shd[div_wsel] <= div_wdata.
  - div_act loads from div_shd in the cycle cnt==N-1 (the wrap), so the running period is never truncated.
  - Same-cycle write and wrap: the new value is loaded at that wrap.
  - div_wsel >= NUM_CH: write ignored.
- Stopped channel (div_act=0): cnt held 0, dclk_vec[i]=0, wrap_vec[i]=0.
  - div_act reloads from div_shd every cycle, so a nonzero write starts the channel on the next cycle with cnt=0.
  - First high occurs after N cycles.
- Writing 0 to a running channel: the channel stops at its next wrap.
- en=0: cnt, div_act, dclk_vec, wrap_vec all hold. Shadow writes are still accepted; select changes stay pending.
- Select switch:
  - active_sel <= sel in the cycle wrap condition (cnt==N-1) of the currently active channel is true, or immediately if the active channel is stopped.
  - sel >= NUM_CH: request ignored (active_sel unchanged, sel_busy=1).
  - sel changing again while pending: only the latest value is taken.
- Arithmetic: counter compare uses CNT_W-bit unsigned; no overflow path since cnt < N <= 2^CNT_W-1.

Optional Feature:
- Macro CLKDIV_DUTY50_EN.
- Defined: dclk_vec[i] is a near-50% square wave, high for ceil(N/2) cycles starting at the cycle after wrap, low for floor(N/2).
  - N=1: constant 1. N=2: 1,0. N=3: 1,1,0.
  - wrap_vec is unchanged, and select switching still keys on wrap.
- Undefined: pulse mode as described above.

Decomposition:
- Package clkdiv_pkg holds:
  - CNT_W default;
  - DIV_STOP constant (0);
  - SEL_W helper function;
  - typedef div_t (logic [CNT_W-1:0]).
- Sub-module clkdiv_channel: one counter, shadow/active ratio registers, dclk/wrap generation, including the CLKDIV_DUTY50_EN variant.
- Top level instantiates NUM_CH channels plus write decode and the select FSM (IDLE/PENDING, implied by sel != active_sel).

Test Plan:
- Reset check: release rst with defaults, en=1 -> all dclk_vec = 1 at reset, then 0,1,0,1 on every channel (N=2); dclk follows ch0.
- Ratio write: write N=5 to ch1 mid-period -> current period of 2 completes, then high 1/low 4 repeating; other channels unaffected.
- Stop/restart: write 0 to ch2 -> stops at next wrap with output 0; write 3 -> first high 3 cycles later, then period 3.
- Switch with a slow active channel: ch0 N=7, ch3 N=4, sel 0->3 -> sel_busy=1 until ch0 wraps; active_sel=3 the next cycle; no dclk pulse shorter than 1 clk.
- Enable/reset corners: en=0 for 10 cycles -> outputs frozen, resume exact phase. Assert rst mid-period -> all outputs 1 and ratios back to DEFAULT_DIV immediately, asynchronously.
- With CLKDIV_DUTY50_EN: N=5 -> 1,1,1,0,0 repeating; N=1 -> constant 1.
